// File: rtl/sobel_gcd_pkg.sv
// Shared definitions for the sobel/gcd tile SPI register bank: address map
// constants and the frame-controller state encoding.
package sobel_gcd_pkg;

  localparam int SPI_ADDR_BITS = 7;
  localparam logic [SPI_ADDR_BITS-1:0] ADDR_RO_BASE = 7'h40;
  localparam logic [SPI_ADDR_BITS-1:0] ADDR_CMD     = 7'h7F;

  typedef enum logic [2:0] {
    WAIT_CS_HIGH = 3'd0,
    IDLE         = 3'd1,
    CMD          = 3'd2,
    DATA         = 3'd3,
    DONE         = 3'd4
  } spi_rb_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin followed by a single
// history flop that yields one-cycle rise/fall events in the clk_i domain.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus edge-detect history flop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_accel_regbank.sv
// Oversampled mode-0 SPI slave exposing RW control words, RO status words and
// a command register that fires per-accelerator start pulses.
module spi_accel_regbank
  import sobel_gcd_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REGS    = 8,
  parameter int NUM_START   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           spi_sck_i,
  input  logic                           spi_sdi_i,
  input  logic                           spi_cs_i,
  output logic                           spi_sdo_o,
  output logic                           spi_sdo_oe_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_strobe_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
  output logic [NUM_START-1:0]           start_o,
  output logic                           frame_err_o,
  output logic                           busy_o
);

  localparam int CNT_W = $clog2(8 + DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_RD_LOAD   = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(8 + DATA_WIDTH - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(spi_sck_i),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(spi_cs_i),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
    .clk_i(clk_i), .reset_i(reset_i), .d_i(spi_sdi_i),
    .level_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sck_lvl, sdi_rise, sdi_fall};

  spi_rb_state_e                 state_q;
  logic [CNT_W-1:0]              bitcnt_q;
  logic [7:0]                    cmd_q;
  logic [DATA_WIDTH-1:0]         data_q;
  logic [DATA_WIDTH-1:0]         shreg_q;
  logic                          overrun_q;
  logic                          sdo_oe_q;
  logic                          busy_q;
  logic                          frame_err_q;
  logic [NUM_REGS-1:0]           wr_strobe_q;
  logic [NUM_START-1:0]          start_q;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q;

  logic [SPI_ADDR_BITS-1:0] addr_d;
  logic                     is_rw_d, is_ro_d, is_cmd_d, mapped_d;
  logic [DATA_WIDTH-1:0]    rd_word_d;

  // Address decode and read-word mux; unmapped reads fall through to zero.
  always_comb begin
    addr_d    = cmd_q[SPI_ADDR_BITS-1:0];
    is_rw_d   = 1'b0;
    is_ro_d   = 1'b0;
    rd_word_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      is_rw_d   = is_rw_d | (addr_d == SPI_ADDR_BITS'(k));
      is_ro_d   = is_ro_d | (addr_d == ADDR_RO_BASE + SPI_ADDR_BITS'(k));
      rd_word_d = rd_word_d
                | ((addr_d == SPI_ADDR_BITS'(k)) ? regs_q[k*DATA_WIDTH +: DATA_WIDTH] : '0)
                | ((addr_d == ADDR_RO_BASE + SPI_ADDR_BITS'(k)) ?
                   status_i[k*DATA_WIDTH +: DATA_WIDTH] : '0);
    end
    is_cmd_d = (addr_d == ADDR_CMD);
    mapped_d = is_rw_d | is_ro_d | is_cmd_d;
  end

  // Frame controller, shift registers, register array and pulse outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= WAIT_CS_HIGH;
      bitcnt_q    <= '0;
      cmd_q       <= 8'h00;
      data_q      <= '0;
      shreg_q     <= '0;
      overrun_q   <= 1'b0;
      sdo_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wr_strobe_q <= '0;
      start_q     <= '0;
      regs_q      <= '0;
    end else begin
      wr_strobe_q <= '0;
      start_q     <= '0;
      frame_err_q <= 1'b0;
      case (state_q)
        WAIT_CS_HIGH: begin
          if (cs_lvl) state_q <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state_q   <= CMD;
            busy_q    <= 1'b1;
            bitcnt_q  <= '0;
            cmd_q     <= 8'h00;
            data_q    <= '0;
            overrun_q <= 1'b0;
          end
        end
        CMD, DATA, DONE: begin
          if (cs_rise) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            sdo_oe_q <= 1'b0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            // Only a complete, non-overrun frame to a mapped address may commit.
            if (state_q != DONE || overrun_q || !mapped_d) begin
              frame_err_q <= 1'b1;
            end else if (!cmd_q[7]) begin
              if (is_rw_d) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                  if (addr_d == SPI_ADDR_BITS'(k)) begin
                    regs_q[k*DATA_WIDTH +: DATA_WIDTH] <= data_q;
                    wr_strobe_q[k]                     <= 1'b1;
                  end
                end
              end else if (is_cmd_d) begin
                start_q <= data_q[NUM_START-1:0];
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end else begin
            if (sck_rise) begin
              case (state_q)
                CMD: begin
                  cmd_q    <= {cmd_q[6:0], sdi_lvl};
                  bitcnt_q <= bitcnt_q + CNT_W'(1);
                  if (bitcnt_q == CNT_CMD_LAST) state_q <= DATA;
                end
                DATA: begin
                  data_q   <= {data_q[DATA_WIDTH-2:0], sdi_lvl};
                  bitcnt_q <= bitcnt_q + CNT_W'(1);
                  if (bitcnt_q == CNT_DATA_LAST) state_q <= DONE;
                end
                DONE: overrun_q <= 1'b1;
                default: overrun_q <= overrun_q;
              endcase
            end
            if (sck_fall) begin
              if (state_q == DATA && bitcnt_q == CNT_RD_LOAD && cmd_q[7]) begin
                shreg_q  <= rd_word_d;
                sdo_oe_q <= 1'b1;
              end else if (sdo_oe_q) begin
                shreg_q <= {shreg_q[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
        end
        default: state_q <= WAIT_CS_HIGH;
      endcase
    end
  end

  assign spi_sdo_o    = shreg_q[DATA_WIDTH-1];
  assign spi_sdo_oe_o = sdo_oe_q;
  assign regs_o       = regs_q;
  assign wr_strobe_o  = wr_strobe_q;
  assign start_o      = start_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_spi_accel_regbank.sv
// Scoreboard bench for spi_accel_regbank: drives mode-0 SPI frames and checks
// commits, start pulses, frame errors and read-back data against a model.
module tb_spi_accel_regbank;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int NS = 4;

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             spi_sck_i = 1'b0;
  logic             spi_sdi_i = 1'b0;
  logic             spi_cs_i = 1'b1;
  logic             spi_sdo_o, spi_sdo_oe_o;
  logic [NR*DW-1:0] regs_o;
  logic [NR-1:0]    wr_strobe_o;
  logic [NR*DW-1:0] status_i;
  logic [NS-1:0]    start_o;
  logic             frame_err_o, busy_o;

  spi_accel_regbank #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_START(NS), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .spi_sck_i(spi_sck_i), .spi_sdi_i(spi_sdi_i),
    .spi_cs_i(spi_cs_i), .spi_sdo_o(spi_sdo_o), .spi_sdo_oe_o(spi_sdo_oe_o),
    .regs_o(regs_o), .wr_strobe_o(wr_strobe_o), .status_i(status_i),
    .start_o(start_o), .frame_err_o(frame_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int err_cnt = 0;

  logic [NR*DW-1:0] model_regs = '0;
  logic [NR-1:0]    exp_strb_q[$];
  logic [NR*DW-1:0] exp_regs_q[$];
  logic [NS-1:0]    exp_start_q[$];
  int               exp_err_q[$];
  logic [DW-1:0]    exp_rd_q[$];

  task automatic check_eq(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops scoreboard entries whenever the DUT emits a pulse.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (frame_err_o) err_cnt++;
      if (wr_strobe_o != '0) begin
        if (exp_strb_q.size() == 0) check_eq("wr_unexpected", wr_strobe_o, '0);
        else begin
          check_eq("wr_strobe", wr_strobe_o, exp_strb_q.pop_front());
          check_eq("wr_regs", regs_o, exp_regs_q.pop_front());
        end
      end
      if (start_o != '0) begin
        if (exp_start_q.size() == 0) check_eq("start_unexpected", start_o, '0);
        else check_eq("start", start_o, exp_start_q.pop_front());
      end
    end
  end

  task automatic push_write(input logic [6:0] a, input logic [DW-1:0] d);
    logic [NR-1:0] one;
    one = 8'h01;
    model_regs[a*DW +: DW] = d;
    exp_strb_q.push_back(one << a);
    exp_regs_q.push_back(model_regs);
  endtask

  task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [DW-1:0] data,
                           input int nbits, input int rst_at);
    logic [23:0]   word;
    logic [DW-1:0] rd;
    logic          oe_all, oe_any, busy_mid;
    int            err_before;
    word = {rw, addr, data};
    rd = '0; oe_all = 1'b1; oe_any = 1'b0; busy_mid = 1'b0;
    err_before = err_cnt;
    spi_cs_i = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset_i = 1'b1;
        repeat (4) @(negedge clk);
        reset_i = 1'b0;
        model_regs = '0;
      end
      spi_sdi_i = (i < 24) ? word[23-i] : 1'b0;
      repeat (8) @(negedge clk);
      spi_sck_i = 1'b1;
      if (i >= 8 && i < 24) begin
        rd[23-i] = spi_sdo_o;
        oe_all   = oe_all & spi_sdo_oe_o;
      end
      oe_any = oe_any | spi_sdo_oe_o;
      if (i == 2) busy_mid = busy_o;
      repeat (8) @(negedge clk);
      spi_sck_i = 1'b0;
    end
    repeat (8) @(negedge clk);
    spi_cs_i = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("frame_err_count", err_cnt - err_before, exp_err_q.pop_front());
    if (rw && nbits == 24) begin
      check_eq("read_data", rd, exp_rd_q.pop_front());
      check_eq("read_oe", oe_all, 1'b1);
    end else begin
      check_eq("write_oe", oe_any, 1'b0);
    end
    check_eq("busy_mid", busy_mid, 1'b1);
    check_eq("busy_after", busy_o, 1'b0);
    check_eq("regs_after", regs_o, model_regs);
  endtask

  initial begin
    for (int k = 0; k < NR; k++) status_i[k*DW +: DW] = 16'hB000 + 16'(k);
    status_i[1*DW +: DW] = 16'hBEEF;
    status_i[7*DW +: DW] = 16'h7777;
    repeat (5) @(negedge clk);
    check_eq("rst_regs", regs_o, '0);
    check_eq("rst_strobe", wr_strobe_o, '0);
    check_eq("rst_sdo", spi_sdo_o, 1'b0);
    check_eq("rst_oe", spi_sdo_oe_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_start_err", {start_o, frame_err_o}, '0);
    reset_i = 1'b0;
    repeat (10) @(negedge clk);

    push_write(7'd2, 16'h1234);  exp_err_q.push_back(0); run_frame(1'b0, 7'd2, 16'h1234, 24, -1);
    push_write(7'd7, 16'hCAFE);  exp_err_q.push_back(0); run_frame(1'b0, 7'd7, 16'hCAFE, 24, -1);
    exp_rd_q.push_back(16'h1234); exp_err_q.push_back(0); run_frame(1'b1, 7'h02, 16'h0000, 24, -1);
    exp_rd_q.push_back(16'hBEEF); exp_err_q.push_back(0); run_frame(1'b1, 7'h41, 16'h0000, 24, -1);
    exp_rd_q.push_back(16'h7777); exp_err_q.push_back(0); run_frame(1'b1, 7'h47, 16'h0000, 24, -1);
    exp_start_q.push_back(4'b0101); exp_err_q.push_back(0); run_frame(1'b0, 7'h7F, 16'h0005, 24, -1);
    exp_err_q.push_back(1); run_frame(1'b0, 7'd1, 16'hFFFF, 20, -1);
    push_write(7'd1, 16'hA5A5);  exp_err_q.push_back(0); run_frame(1'b0, 7'd1, 16'hA5A5, 24, -1);
    exp_rd_q.push_back(16'h0000); exp_err_q.push_back(1); run_frame(1'b1, 7'h30, 16'h0000, 24, -1);
    exp_rd_q.push_back(16'h0000); exp_err_q.push_back(1); run_frame(1'b1, 7'h48, 16'h0000, 24, -1);
    exp_err_q.push_back(1); run_frame(1'b0, 7'h41, 16'h9999, 24, -1);
    exp_err_q.push_back(1); run_frame(1'b0, 7'd4, 16'h4444, 25, -1);
    exp_err_q.push_back(0); run_frame(1'b0, 7'd5, 16'h1111, 24, 10);
    push_write(7'd3, 16'h5555);  exp_err_q.push_back(0); run_frame(1'b0, 7'd3, 16'h5555, 24, -1);
    exp_rd_q.push_back(16'h5555); exp_err_q.push_back(0); run_frame(1'b1, 7'h03, 16'h0000, 24, -1);

    check_eq("wr_pending", exp_strb_q.size(), '0);
    check_eq("start_pending", exp_start_q.size(), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
